// File: rtl/trap_pkg.sv
// Shared constants and types for the machine-mode trap controller.
package trap_pkg;

  localparam logic [11:0] CSR_MSTATUS  = 12'h300;
  localparam logic [11:0] CSR_MIE      = 12'h304;
  localparam logic [11:0] CSR_MTVEC    = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH = 12'h340;
  localparam logic [11:0] CSR_MEPC     = 12'h341;
  localparam logic [11:0] CSR_MCAUSE   = 12'h342;
  localparam logic [11:0] CSR_MTVAL    = 12'h343;
  localparam logic [11:0] CSR_MIP      = 12'h344;

  localparam logic [4:0] CAUSE_M_EXT_BASE  = 5'd16;
  localparam logic [3:0] CAUSE_ILLEGAL     = 4'd2;
  localparam logic [3:0] CAUSE_LOAD_FAULT  = 4'd5;
  localparam logic [3:0] CAUSE_STORE_FAULT = 4'd7;
  localparam logic [3:0] CAUSE_ECALL_M     = 4'd11;

  localparam logic [1:0] WSC_READ  = 2'b00;
  localparam logic [1:0] WSC_WRITE = 2'b01;
  localparam logic [1:0] WSC_SET   = 2'b10;
  localparam logic [1:0] WSC_CLEAR = 2'b11;

  localparam int unsigned MSTATUS_MIE_BIT  = 3;
  localparam int unsigned MSTATUS_MPIE_BIT = 7;
  localparam int unsigned IRQ_BIT_BASE     = 16;
  localparam int unsigned IRQ_ID_W         = 4;

  typedef enum logic {
    ST_IDLE,
    ST_REDIRECT
  } state_e;

endpackage

// File: rtl/irq_pend_prio.sv
// Edge-latched pending bits (mip) and lowest-index-first priority encoder.
module irq_pend_prio
  import trap_pkg::*;
#(
  parameter int unsigned NUM_IRQ = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_IRQ-1:0]  irq_in,
  input  logic [NUM_IRQ-1:0]  irq_en,
  input  logic                take,
  input  logic [IRQ_ID_W-1:0] take_id,
  input  logic                csr_we,
  input  logic [NUM_IRQ-1:0]  csr_wval,
  output logic [NUM_IRQ-1:0]  pending,
  output logic                irq_any,
  output logic [IRQ_ID_W-1:0] irq_id
);

  logic [NUM_IRQ-1:0] irq_prev;
  logic [NUM_IRQ-1:0] rise;
  logic [NUM_IRQ-1:0] masked;
  logic [NUM_IRQ-1:0] take_mask;

  assign rise      = irq_in & ~irq_prev;
  assign masked    = pending & irq_en;
  assign take_mask = take ? (NUM_IRQ'(1) << take_id) : '0;

  // Scan from the top so the lowest active index is the one left standing.
  always_comb begin
    irq_any = |masked;
    irq_id  = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (masked[i]) irq_id = IRQ_ID_W'(i);
    end
  end

  // A new edge in the same cycle as a clear keeps the bit set.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      irq_prev <= '0;
      pending  <= '0;
    end else begin
      irq_prev <= irq_in;
      pending  <= ((csr_we ? csr_wval : pending) & ~take_mask) | rise;
    end
  end

endmodule

// File: rtl/trap_ctrl_vec.sv
// Machine-mode trap controller: CSR file, interrupt/exception/mret sequencing, vectored redirect.
module trap_ctrl_vec
  import trap_pkg::*;
#(
  parameter int unsigned     XLEN        = 32,
  parameter int unsigned     NUM_IRQ     = 8,
  parameter bit              VECTORED    = 1'b1,
  parameter logic [XLEN-1:0] MTVEC_RESET = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               csr_rw_in,
  input  logic [1:0]         csr_wsc_mode_in,
  input  logic [11:0]        csr_addr_in,
  input  logic [XLEN-1:0]    csr_wdata_in,
  output logic [XLEN-1:0]    csr_rdata_out,
  input  logic [NUM_IRQ-1:0] irq_in,
  input  logic               exc_valid,
  input  logic [3:0]         exc_code,
  input  logic [XLEN-1:0]    exc_tval,
  input  logic [XLEN-1:0]    epc_cur,
  input  logic [XLEN-1:0]    epc_next,
  input  logic               mret,
  output logic [XLEN-1:0]    pc_redirect,
  output logic               redirect_valid,
  output logic               flush,
  output logic               regwrite_cancel
);

  state_e             state;
  logic               mstatus_mie, mstatus_mpie;
  logic [NUM_IRQ-1:0] mie_q, mip_q;
  logic [XLEN-1:0]    mtvec_q, mscratch_q, mepc_q, mcause_q, mtval_q;

  logic                irq_any;
  logic [IRQ_ID_W-1:0] irq_id;
  logic                idle, irq_take, exc_take, mret_take, trap_take, csr_we;
  logic [4:0]          irq_cause;
  logic [XLEN-1:0]     csr_new, mtvec_base, mepc_rd, trap_target;

  assign idle      = (state == ST_IDLE);
  assign irq_take  = idle & mstatus_mie & irq_any;
  assign exc_take  = idle & ~irq_take & exc_valid;
  assign mret_take = idle & ~irq_take & ~exc_valid & mret;
  assign trap_take = irq_take | exc_take;
  assign csr_we    = csr_rw_in & (csr_wsc_mode_in != WSC_READ) & idle & ~trap_take & ~mret_take;

  assign irq_cause  = CAUSE_M_EXT_BASE + 5'(irq_id);
  assign mtvec_base = mtvec_q & ~XLEN'(3);
  assign mepc_rd    = mepc_q & ~XLEN'(3);

  assign flush           = rst & (~idle | trap_take | mret_take);
  assign regwrite_cancel = rst & trap_take;

  irq_pend_prio #(.NUM_IRQ(NUM_IRQ)) u_pend (
    .clk      (clk),
    .rst      (rst),
    .irq_in   (irq_in),
    .irq_en   (mie_q),
    .take     (irq_take),
    .take_id  (irq_id),
    .csr_we   (csr_we && (csr_addr_in == CSR_MIP)),
    .csr_wval (csr_new[IRQ_BIT_BASE +: NUM_IRQ]),
    .pending  (mip_q),
    .irq_any  (irq_any),
    .irq_id   (irq_id)
  );

  // CSR read mux; unimplemented bits and addresses read as zero.
  always_comb begin
    csr_rdata_out = '0;
    case (csr_addr_in)
      CSR_MSTATUS: begin
        csr_rdata_out[MSTATUS_MIE_BIT]  = mstatus_mie;
        csr_rdata_out[MSTATUS_MPIE_BIT] = mstatus_mpie;
      end
      CSR_MIE:      csr_rdata_out = XLEN'(mie_q) << IRQ_BIT_BASE;
      CSR_MTVEC:    csr_rdata_out = mtvec_q;
      CSR_MSCRATCH: csr_rdata_out = mscratch_q;
      CSR_MEPC:     csr_rdata_out = mepc_rd;
      CSR_MCAUSE:   csr_rdata_out = mcause_q;
      CSR_MTVAL:    csr_rdata_out = mtval_q;
      CSR_MIP:      csr_rdata_out = XLEN'(mip_q) << IRQ_BIT_BASE;
      default:      csr_rdata_out = '0;
    endcase
  end

  always_comb begin
    case (csr_wsc_mode_in)
      WSC_WRITE: csr_new = csr_wdata_in;
      WSC_SET:   csr_new = csr_rdata_out | csr_wdata_in;
      WSC_CLEAR: csr_new = csr_rdata_out & ~csr_wdata_in;
      default:   csr_new = csr_rdata_out;
    endcase
  end

  always_comb begin
    trap_target = mtvec_base;
    if (VECTORED && (mtvec_q[1:0] == 2'b01) && irq_take)
      trap_target = mtvec_base + (XLEN'(irq_cause) << 2);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= ST_IDLE;
      mstatus_mie    <= 1'b0;
      mstatus_mpie   <= 1'b0;
      mie_q          <= '0;
      mtvec_q        <= MTVEC_RESET;
      mscratch_q     <= '0;
      mepc_q         <= '0;
      mcause_q       <= '0;
      mtval_q        <= '0;
      pc_redirect    <= '0;
      redirect_valid <= 1'b0;
    end else begin
      redirect_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (trap_take) begin
            state          <= ST_REDIRECT;
            redirect_valid <= 1'b1;
            pc_redirect    <= trap_target;
            mstatus_mpie   <= mstatus_mie;
            mstatus_mie    <= 1'b0;
            if (irq_take) begin
              mepc_q   <= epc_next;
              mcause_q <= {1'b1, (XLEN-1)'(irq_cause)};
              mtval_q  <= '0;
            end else begin
              mepc_q   <= epc_cur;
              mcause_q <= XLEN'(exc_code);
              mtval_q  <= exc_tval;
            end
          end else if (mret_take) begin
            state          <= ST_REDIRECT;
            redirect_valid <= 1'b1;
            pc_redirect    <= mepc_rd;
            mstatus_mie    <= mstatus_mpie;
            mstatus_mpie   <= 1'b1;
          end else if (csr_we) begin
            case (csr_addr_in)
              CSR_MSTATUS: begin
                mstatus_mie  <= csr_new[MSTATUS_MIE_BIT];
                mstatus_mpie <= csr_new[MSTATUS_MPIE_BIT];
              end
              CSR_MIE:      mie_q      <= csr_new[IRQ_BIT_BASE +: NUM_IRQ];
              CSR_MTVEC:    mtvec_q    <= csr_new;
              CSR_MSCRATCH: mscratch_q <= csr_new;
              CSR_MEPC:     mepc_q     <= csr_new;
              CSR_MCAUSE:   mcause_q   <= csr_new;
              CSR_MTVAL:    mtval_q    <= csr_new;
              default: ;
            endcase
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
